// File: rtl/fib_pkg.sv
// Shared types and default widths for the Fibonacci SRAM initiator.
package fib_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_REQ,
    READ_WAIT,
    OUT,
    DONE
  } state_e;

endpackage

// File: rtl/fib_sram_ctrl_if.sv
// SRAM pin bundle plus the outgoing term stream, seen from the controller (master)
// and from the SRAM/consumer side (slave).
interface fib_sram_ctrl_if
  import fib_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  sram_we;
  logic                  sram_oe;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output sram_we, sram_oe, sram_addr, sram_wdata,
    output out_data, out_valid, out_last,
    input  sram_rdata, out_ready
  );

  modport slave (
    input  sram_we, sram_oe, sram_addr, sram_wdata,
    input  out_data, out_valid, out_last,
    output sram_rdata, out_ready
  );

endinterface

// File: rtl/fib_step.sv
// Fibonacci pair (a, b) with per-operand wrap flags; a is the term to write now,
// its flag says whether its true value no longer fits in DATA_WIDTH bits.
module fib_step
  import fib_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  advance_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic                  a_wrap_o
);

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  a_wrap_q, a_wrap_d, b_wrap_q, b_wrap_d;
  logic [DATA_WIDTH:0]   sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    a_wrap_d = a_wrap_q;
    b_wrap_d = b_wrap_q;
    if (clear_i) begin
      a_d      = '0;
      b_d      = DATA_WIDTH'(1);
      a_wrap_d = 1'b0;
      b_wrap_d = 1'b0;
    end else if (advance_i) begin
      a_d      = b_q;
      a_wrap_d = b_wrap_q;
      b_d      = sum[DATA_WIDTH-1:0];
      // Once any ancestor wrapped, every later term is wrong too.
      b_wrap_d = sum[DATA_WIDTH] | a_wrap_q | b_wrap_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      a_wrap_q <= 1'b0;
      b_wrap_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      a_wrap_q <= a_wrap_d;
      b_wrap_q <= b_wrap_d;
    end
  end

  assign a_o      = a_q;
  assign a_wrap_o = a_wrap_q;

endmodule

// File: rtl/fib_sram_ctrl.sv
// Writes F(0)..F(count) into the SRAM, then reads them back and streams them out.
// All SRAM pins are decoded from registered state so no input reaches an output.
module fib_sram_ctrl
  import fib_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  fib_sram_ctrl_if.master       bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  logic                  step_clear;
  logic                  step_advance;
  logic [DATA_WIDTH-1:0] term;
  logic                  term_wrap;

  fib_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (step_clear),
    .advance_i (step_advance),
    .a_o       (term),
    .a_wrap_o  (term_wrap)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    ovf_d        = ovf_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    step_clear   = 1'b0;
    step_advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          last_d     = count;
          idx_d      = '0;
          ovf_d      = 1'b0;
          step_clear = 1'b1;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        step_advance = 1'b1;
        if (term_wrap) ovf_d = 1'b1;
        if (idx_q == last_q) begin
          idx_d   = '0;
          state_d = READ_REQ;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      READ_REQ: state_d = READ_WAIT;
      READ_WAIT: begin
        out_data_d  = bus.sram_rdata;
        out_last_d  = (idx_q == last_q);
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = READ_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;

  // Address and write data are forced to zero outside the access states.
  assign bus.sram_we    = (state_q == WRITE);
  assign bus.sram_oe    = (state_q == READ_REQ);
  assign bus.sram_addr  = (state_q == WRITE || state_q == READ_REQ) ? idx_q : '0;
  assign bus.sram_wdata = (state_q == WRITE) ? term : '0;

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_fib_sram_ctrl.sv
// Scoreboard bench for fib_sram_ctrl: directed runs push expected SRAM writes and
// stream beats into queues; a negedge monitor pops and compares them.
module tb_fib_sram_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       overflow;

  fib_sram_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  fib_sram_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bus      (bus)
  );

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
    logic       ovf;
  } wr_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } out_t;

  wr_t  wr_q[$];
  out_t out_q[$];

  // F(k) mod 256, worked out by hand: 377 -> 121, 610 -> 98.
  logic [7:0] fib_tab [16] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                               8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};

  int   total = 0;
  int   bad   = 0;
  int   n_pop = 0;
  bit   mon_en = 1'b1;
  int   ready_mode = 0;   // 0: ready high, 1: random, 2: ready low
  logic [7:0] mem [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM model: write at the we edge, registered read data held until the next oe.
  always @(posedge clk) begin
    if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
    if (bus.sram_oe) bus.sram_rdata <= mem[bus.sram_addr];
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (bus.sram_we && bus.sram_oe) check("we_oe_exclusive", 32'(1), 32'(0));
    if (rst_n && mon_en) begin
      if (bus.sram_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'(1), 32'(0));
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", 32'(bus.sram_addr), 32'(w.addr));
          check("wr_data", 32'(bus.sram_wdata), 32'(w.data));
          check("ovf_before_write", 32'(overflow), 32'(w.ovf));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (out_q.size() == 0) begin
          check("unexpected_beat", 32'(1), 32'(0));
        end else begin
          out_t o;
          o = out_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(o.data));
          check("out_last", 32'(bus.out_last), 32'(o.last));
        end
        n_pop++;
      end
    end
  end

  task automatic push_expect(input int n_last);
    for (int k = 0; k <= n_last; k++) begin
      wr_q.push_back('{addr: 4'(k), data: fib_tab[k], ovf: (k >= 15)});
      out_q.push_back('{data: fib_tab[k], last: (k == n_last)});
    end
  endtask

  task automatic pulse_start(input logic [3:0] c);
    @(posedge clk);
    #1;
    count = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'(1));
  endtask

  task automatic finish_run(input bit exp_ovf, input bit poke_done);
    wait_done();
    check("ovf_at_done", 32'(overflow), 32'(exp_ovf));
    check("busy_at_done", 32'(busy), 32'(0));
    if (poke_done) begin
      start = 1'b1;
      count = 4'd12;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'(0));
    check("busy_after", 32'(busy), 32'(0));
    check("ovf_held", 32'(overflow), 32'(exp_ovf));
    check("wr_q_drained", 32'(wr_q.size()), 32'(0));
    check("out_q_drained", 32'(out_q.size()), 32'(0));
  endtask

  task automatic run(input int n_last, input bit exp_ovf);
    push_expect(n_last);
    pulse_start(4'(n_last));
    finish_run(exp_ovf, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hee;
    rst_n = 1'b0;
    start = 1'b0;
    count = 4'd0;
    #1;
    check("reset_outputs", 32'({busy, done, overflow, bus.out_data, bus.out_valid, bus.out_last,
                                bus.sram_we, bus.sram_oe, bus.sram_addr, bus.sram_wdata}), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Eight terms, ready tied high.
    run(7, 1'b0);

    // Whole memory; wraps from F(14) onward.
    run(15, 1'b1);

    // Backpressure on term 2 (value 1); the new start also clears overflow.
    push_expect(3);
    n_pop = 0;
    pulse_start(4'd3);
    for (int i = 0; i < 50 && n_pop < 2; i++) @(negedge clk);
    check("reached_term2", 32'(n_pop), 32'(2));
    ready_mode = 2;
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.out_valid), 32'(1));
      check("stall_data", 32'(bus.out_data), 32'(1));
      check("stall_last", 32'(bus.out_last), 32'(0));
    end
    ready_mode = 0;
    finish_run(1'b0, 1'b0);

    // Random ready toggling.
    ready_mode = 1;
    run(3, 1'b0);
    ready_mode = 0;

    // Single term.
    run(0, 1'b0);

    // Stray starts in WRITE, OUT and DONE must not disturb a count=5 run.
    push_expect(5);
    pulse_start(4'd5);
    count = 4'd12;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
    check("out_valid_for_poke", 32'(bus.out_valid), 32'(1));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_run(1'b0, 1'b1);

    // Reset in the middle of the write phase.
    mon_en = 1'b0;
    pulse_start(4'd9);
    repeat (2) @(posedge clk);
    #1;
    check("mid_write_we", 32'(bus.sram_we), 32'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({busy, done, overflow, bus.out_data, bus.out_valid, bus.out_last,
                                  bus.sram_we, bus.sram_oe, bus.sram_addr, bus.sram_wdata}), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'(0));
    run(4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
